fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage of the multicycle 16-bit RISC core.
- Sits between the control unit and instruction memory:
  - Consumes the control unit's fetch enable and next-PC select.
  - Computes and holds the PC, runs a request/acknowledge read to instruction memory, and latches the instruction register (IR).
  - Returns the opcode to the control unit and the instruction and link address to decode.

Parameters:
- ADDR_W, 16, PC / instruction-memory address width.
- INSTR_W, 16, instruction width; opcode is IR[INSTR_W-1:INSTR_W-4].
- RESET_PC, 16'h0000, PC value after reset.
- BR_IMM_W, 6, width of the branch offset field IR[BR_IMM_W-1:0], sign-extended.
- JMP_IMM_W, 12, width of the jump target field IR[JMP_IMM_W-1:0].
- TIMEOUT, 15, maximum cycles waiting for imem_ack before fault.

Ports:
- clock, input, 1, single clock; all state updates on posedge.
- reset, input, 1, asynchronous active-high reset.
- en_if, input, 1, fetch enable from control unit (level, held high for the fetch stage).
- sig_pc_src, input, 4, next-PC select: 0 default PC+1; 1 PC+sext(branch imm); 2 {PC[ADDR_W-1:JMP_IMM_W], jump imm}; 3 ret_addr; 4..15 treated as 0.
- ret_addr, input, ADDR_W, return address (R7 contents) from the register file.
- imem_req, output, 1, memory read request.
- imem_addr, output, ADDR_W, memory read address.
- imem_ack, input, 1, memory acknowledge; imem_rdata is valid in the ack cycle.
- imem_rdata, input, INSTR_W, memory read data.
- pc, output, ADDR_W, address of the instruction currently in IR.
- instr, output, INSTR_W, instruction register.
- opcode, output, 4, instr[INSTR_W-1:INSTR_W-4], to the control unit's instructionCode.
- link_addr, output, ADDR_W, pc+1 (CALL link value for R7).
- instr_valid, output, 1, one-cycle pulse when IR is updated.
- busy, output, 1, high while a fetch is in progress.
- fault, output, 1, sticky: memory timeout.
- overrun, output, 1, sticky: fetch start requested while busy.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-fetch) sets:
  - state=IDLE, pc=RESET_PC, instr=0, first=1.
  - imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, busy=0, fault=0, overrun=0, timer=0.
- Start condition: rising edge of en_if, detected via a registered en_if_q (reset 0). A held level does not retrigger.
- Next-PC computation (at start):
  - If first=1: next=pc and first is cleared. The first fetch uses RESET_PC regardless of sig_pc_src.
  - Otherwise next is selected by sig_pc_src, computed from the current pc and IR:
    - Default: pc+1.
    - Branch: pc + sext(instr[BR_IMM_W-1:0]).
    - Jump: {pc[ADDR_W-1:JMP_IMM_W], instr[JMP_IMM_W-1:0]}.
    - Return: ret_addr.
  - All additions are modulo 2^ADDR_W. Wrap-around is required: 16'hFFFF+1 = 16'h0000, and 16'h0002 + (-4) = 16'hFFFE.
- FSM states and transitions:
  - IDLE: on start, pc<=next, imem_addr<=next, imem_req<=1, busy<=1, timer<=0; go to WAIT.
  - WAIT: imem_req held high and imem_addr stable.
    - On imem_ack: instr<=imem_rdata, imem_req<=0, instr_valid<=1 (next cycle, one cycle only), busy<=0; go to IDLE.
    - Otherwise timer increments. When timer reaches TIMEOUT with no ack: fault<=1, imem_req<=0, busy<=0, instr unchanged, pc keeps the new address; go to IDLE.
- Minimum latency: en_if rise at edge N → imem_req high after edge N+1. With ack in the first WAIT cycle, instr and instr_valid update at edge N+2.
- imem_ack outside WAIT is ignored.
- A start while busy (in WAIT) does not restart or change the fetch; it sets overrun.
- Outputs are combinational from the registers: opcode from instr, link_addr = pc+1 (wraps).
- fault and overrun clear only on reset.
- A fetch after a fault proceeds normally; pc advances from the faulted address.

Test Plan:
- Reset, then en_if pulse, ack after 1 cycle with rdata=16'h5123 → imem_addr=0000, pc=0000, instr=5123, opcode=5, link_addr=0001, instr_valid one cycle.
- Second en_if rise with sig_pc_src=0, ack after 3 cycles → imem_addr=0001; imem_req high exactly until the ack cycle; busy deasserted with the ack.
- IR=16'h803C (offset -4) at pc=0002, sig_pc_src=1 → fetch address FFFE. Then from pc=FFFF with src=0 → 0000.
- Jump IR=16'hA123 at pc=5010, src=2 → 5123. Then src=3 with ret_addr=0042 → 0042, link_addr=0043.
- Never assert ack → fault set after TIMEOUT=15 WAIT cycles, imem_req low, instr unchanged. Next fetch completes normally with fault still 1.
- en_if toggled low/high while in WAIT → overrun=1, address unchanged. Assert reset mid-WAIT → imem_req drops immediately, pc=0000, first fetch re-uses 0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a req/ack read from instruction
// memory, latches the IR and flags memory timeouts and overlapping starts.
module fetch_unit #(
  parameter int unsigned           ADDR_W    = 16,
  parameter int unsigned           INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]     RESET_PC  = 16'h0000,
  parameter int unsigned           BR_IMM_W  = 6,
  parameter int unsigned           JMP_IMM_W = 12,
  parameter int unsigned           TIMEOUT   = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en_if,
  input  logic [3:0]         sig_pc_src,
  input  logic [ADDR_W-1:0]  ret_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [ADDR_W-1:0]  link_addr,
  output logic               instr_valid,
  output logic               busy,
  output logic               fault,
  output logic               overrun
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_addr;
  logic [INSTR_W-1:0] r_instr;
  logic [TW-1:0]      r_timer;
  logic               r_first;
  logic               r_en_q;
  logic               r_req;
  logic               r_valid;
  logic               r_busy;
  logic               r_fault;
  logic               r_overrun;

  logic               w_start;
  logic [ADDR_W-1:0]  w_br_off;
  logic [ADDR_W-1:0]  w_next;

  assign w_start  = en_if & ~r_en_q;
  assign w_br_off = {{(ADDR_W-BR_IMM_W){r_instr[BR_IMM_W-1]}}, r_instr[BR_IMM_W-1:0]};

  // The very first fetch after reset must land on RESET_PC whatever the select says.
  always_comb begin
    w_next = r_pc + ADDR_W'(1);
    case (sig_pc_src)
      4'd1:    w_next = r_pc + w_br_off;
      4'd2:    w_next = {r_pc[ADDR_W-1:JMP_IMM_W], r_instr[JMP_IMM_W-1:0]};
      4'd3:    w_next = ret_addr;
      default: w_next = r_pc + ADDR_W'(1);
    endcase
    if (r_first) begin
      w_next = r_pc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_addr    <= RESET_PC;
      r_instr   <= '0;
      r_timer   <= '0;
      r_first   <= 1'b1;
      r_en_q    <= 1'b0;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_fault   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_en_q  <= en_if;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_pc    <= w_next;
            r_addr  <= w_next;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_timer <= '0;
            r_first <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_start) begin
            r_overrun <= 1'b1;
          end
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_fault <= 1'b1;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign opcode      = r_instr[INSTR_W-1 -: 4];
  assign link_addr   = r_pc + ADDR_W'(1);
  assign instr_valid = r_valid;
  assign busy        = r_busy;
  assign fault       = r_fault;
  assign overrun     = r_overrun;

endmodule
